// File: rtl/crc32_fcs_append.sv
// Transmit-side framer: forwards payload bytes, zero-pads short frames up to MIN_LEN,
// then appends the reflected Ethernet CRC32 FCS, least significant byte first.
module crc32_fcs_append #(
  parameter bit          PAD_EN  = 1'b1,
  parameter int unsigned MIN_LEN = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic        frame_done,
  output logic [31:0] crc_out
);

  typedef enum logic [1:0] {IDLE, DATA, PAD, FCS} state_t;

  localparam logic [16:0] MIN_LEN_W = 17'(MIN_LEN);

  state_t      state, state_nxt;
  logic [31:0] crc, fcs_hold, crc_base, fcs_word;
  logic [15:0] byte_cnt;
  logic [16:0] cnt_inc;
  logic [1:0]  fcs_idx;
  logic        adv, in_xfer, emit, emit_last, crc_en;
  logic [7:0]  emit_byte;

  function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++)
      c = (c >> 1) ^ (32'hEDB88320 & {32{c[0] ^ d[i]}});
    return c;
  endfunction

  assign adv        = !m_valid || m_ready;
  assign s_ready    = rst && adv && ((state == IDLE) || (state == DATA));
  assign in_xfer    = s_valid && s_ready;
  assign cnt_inc    = {1'b0, byte_cnt} + 17'd1;
  assign fcs_word   = ~crc;
  assign crc_base   = (state == IDLE) ? 32'hFFFF_FFFF : crc;
  assign frame_done = m_valid && m_ready && m_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_xfer) begin
        if (s_last) state_nxt = (PAD_EN && (17'd1 < MIN_LEN_W)) ? PAD : FCS;
        else        state_nxt = DATA;
      end
      DATA: if (in_xfer && s_last)
        state_nxt = (PAD_EN && (cnt_inc < MIN_LEN_W)) ? PAD : FCS;
      PAD:  if (adv && (cnt_inc == MIN_LEN_W)) state_nxt = FCS;
      FCS:  if (adv && (fcs_idx == 2'd3)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    emit      = 1'b0;
    emit_byte = 8'h00;
    emit_last = 1'b0;
    crc_en    = 1'b0;
    case (state)
      IDLE, DATA: begin
        emit      = in_xfer;
        emit_byte = s_data;
        crc_en    = in_xfer;
      end
      PAD: begin
        emit   = adv;
        crc_en = adv;
      end
      FCS: begin
        emit      = adv;
        emit_byte = fcs_word[{fcs_idx, 3'b000} +: 8];
        emit_last = (fcs_idx == 2'd3);
      end
      default: ;
    endcase
  end

  // fcs_hold keeps the finished FCS so crc_out can load it once the last byte actually leaves
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      m_data   <= 8'h00;
      crc      <= 32'hFFFF_FFFF;
      byte_cnt <= 16'd0;
      fcs_idx  <= 2'd0;
      fcs_hold <= 32'd0;
      crc_out  <= 32'd0;
    end else begin
      if (adv) begin
        m_valid <= emit;
        m_last  <= emit && emit_last;
        if (emit) m_data <= emit_byte;
      end
      if (crc_en) crc <= crc_upd(crc_base, emit_byte);
      if ((state == IDLE) && in_xfer)
        byte_cnt <= 16'd1;
      else if (crc_en && (byte_cnt != 16'hFFFF))
        byte_cnt <= byte_cnt + 16'd1;
      if ((state == FCS) && adv) begin
        fcs_idx <= fcs_idx + 2'd1;
        if (fcs_idx == 2'd3) begin
          crc      <= 32'hFFFF_FFFF;
          byte_cnt <= 16'd0;
          fcs_hold <= fcs_word;
        end
      end
      if (frame_done) crc_out <= fcs_hold;
    end
  end

endmodule
